// File: rtl/execute_stage_if.sv
// Bundle between the Decode/Execute register, the execute stage and the ExecuteMemory register.
// master = decode/memory side of the pipeline; slave = the execute stage itself.
interface execute_stage_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             in_valid;
  logic [2:0]       aluop;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] memData_in;
  logic             wbs_in;
  logic             wme_in;
  logic             wm_in;
  logic             ni_in;
  logic [1:0]       mm_in;

  logic             stall;
  logic             out_valid;
  logic [WIDTH-1:0] ALUresult_out;
  logic [WIDTH-1:0] memData_out;
  logic             wbs_out;
  logic             wme_out;
  logic             wm_out;
  logic             ni_out;
  logic [1:0]       mm_out;
  logic             zero_out;

  modport master (
    output flush, in_valid, aluop, srcA, srcB, memData_in,
           wbs_in, wme_in, wm_in, ni_in, mm_in,
    input  stall, out_valid, ALUresult_out, memData_out,
           wbs_out, wme_out, wm_out, ni_out, mm_out, zero_out
  );

  modport slave (
    input  flush, in_valid, aluop, srcA, srcB, memData_in,
           wbs_in, wme_in, wm_in, ni_in, mm_in,
    output stall, out_valid, ALUresult_out, memData_out,
           wbs_out, wme_out, wm_out, ni_out, mm_out, zero_out
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: ALU ops registered in 1 clock; mul/divu run 16 iterative steps, result 17 cycles after presentation.
// Backpressure: stall holds the Decode/Execute register while mul/divu is pending; flush and rst kill work in flight.
module execute_stage #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  execute_stage_if.slave ex_if
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // mul: shifting multiplicand; divu: dividend becoming quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // mul: shifting multiplier;   divu: divisor
  logic [WIDTH-1:0] acc_q, acc_d;   // mul: partial product;       divu: remainder
  logic [WIDTH-1:0] mdat_q, mdat_d;
  logic [3:0]       ctl_q, ctl_d;   // {wbs, wme, wm, ni}
  logic [1:0]       mm_q, mm_d;

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] res_dat_q, res_dat_d;
  logic [WIDTH-1:0] out_mdat_q, out_mdat_d;
  logic [3:0]       out_ctl_q, out_ctl_d;
  logic [1:0]       out_mm_q, out_mm_d;
  logic             zero_q, zero_d;

  logic             is_multi;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] prod_nx, quot_nx, rem_nx;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;

  assign is_multi = (ex_if.aluop[2:1] == 2'b11);

  always_comb begin
    alu_res = '0;
    case (ex_if.aluop)
      3'b000:  alu_res = ex_if.srcA + ex_if.srcB;
      3'b001:  alu_res = ex_if.srcA - ex_if.srcB;
      3'b010:  alu_res = ex_if.srcA & ex_if.srcB;
      3'b011:  alu_res = ex_if.srcA | ex_if.srcB;
      3'b100:  alu_res = ex_if.srcA << ex_if.srcB[3:0];
      3'b101:  alu_res = ex_if.srcA >> ex_if.srcB[3:0];
      default: alu_res = '0;
    endcase
  end

  // A zero divisor always satisfies rem >= divisor, so the quotient saturates to all ones.
  always_comb begin
    prod_nx = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh  = {acc_q, opa_q[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opb_q});
    rem_nx  = rem_ge ? WIDTH'(rem_sh - {1'b0, opb_q}) : rem_sh[WIDTH-1:0];
    quot_nx = {opa_q[WIDTH-2:0], rem_ge};
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    is_div_d   = is_div_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    mdat_d     = mdat_q;
    ctl_d      = ctl_q;
    mm_d       = mm_q;
    out_vld_d  = 1'b0;
    res_dat_d  = '0;
    out_mdat_d = '0;
    out_ctl_d  = '0;
    out_mm_d   = '0;
    if (ex_if.flush) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_if.in_valid && is_multi) begin
            state_d  = BUSY;
            count_d  = '0;
            is_div_d = ex_if.aluop[0];
            opa_d    = ex_if.srcA;
            opb_d    = ex_if.srcB;
            acc_d    = '0;
            mdat_d   = ex_if.memData_in;
            ctl_d    = {ex_if.wbs_in, ex_if.wme_in, ex_if.wm_in, ex_if.ni_in};
            mm_d     = ex_if.mm_in;
          end else if (ex_if.in_valid) begin
            out_vld_d  = 1'b1;
            res_dat_d  = alu_res;
            out_mdat_d = ex_if.memData_in;
            out_ctl_d  = {ex_if.wbs_in, ex_if.wme_in, ex_if.wm_in, ex_if.ni_in};
            out_mm_d   = ex_if.mm_in;
          end
        end
        BUSY: begin
          count_d = count_q + CW'(1);
          if (is_div_q) begin
            acc_d = rem_nx;
            opa_d = quot_nx;
          end else begin
            acc_d = prod_nx;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
          end
          if (count_q == LAST) begin
            state_d    = IDLE;
            count_d    = '0;
            out_vld_d  = 1'b1;
            res_dat_d  = is_div_q ? quot_nx : prod_nx;
            out_mdat_d = mdat_q;
            out_ctl_d  = ctl_q;
            out_mm_d   = mm_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign zero_d = out_vld_d & (res_dat_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      is_div_q   <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      mdat_q     <= '0;
      ctl_q      <= '0;
      mm_q       <= '0;
      out_vld_q  <= 1'b0;
      res_dat_q  <= '0;
      out_mdat_q <= '0;
      out_ctl_q  <= '0;
      out_mm_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      is_div_q   <= is_div_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      mdat_q     <= mdat_d;
      ctl_q      <= ctl_d;
      mm_q       <= mm_d;
      out_vld_q  <= out_vld_d;
      res_dat_q  <= res_dat_d;
      out_mdat_q <= out_mdat_d;
      out_ctl_q  <= out_ctl_d;
      out_mm_q   <= out_mm_d;
      zero_q     <= zero_d;
    end
  end

  assign ex_if.stall = ~ex_if.flush & ~rst &
                       (((state_q == IDLE) & ex_if.in_valid & is_multi) |
                        ((state_q == BUSY) & (count_q != LAST)));

  assign ex_if.out_valid     = out_vld_q;
  assign ex_if.ALUresult_out = res_dat_q;
  assign ex_if.memData_out   = out_mdat_q;
  assign ex_if.wbs_out       = out_ctl_q[3];
  assign ex_if.wme_out       = out_ctl_q[2];
  assign ex_if.wm_out        = out_ctl_q[1];
  assign ex_if.ni_out        = out_ctl_q[0];
  assign ex_if.mm_out        = out_mm_q;
  assign ex_if.zero_out      = zero_q;
endmodule
